// File: rtl/hwpe_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one HCI-style TCDM master port between NumIn
// HWPE engines. A stalled request is locked until granted, and a source-ID
// FIFO routes the in-order responses back to the issuing engine.
// Optional grant/stall statistics counters: define HWPE_TCDM_ARB_STATS_EN.
module hwpe_tcdm_rr_arbiter #(
  parameter int unsigned NumIn          = 2,
  parameter int unsigned DataWidth      = 256,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumIn-1:0]                       en_i,
  input  logic [NumIn-1:0]                       in_req_i,
  output logic [NumIn-1:0]                       in_gnt_o,
  input  logic [NumIn-1:0][AddrWidth-1:0]        in_add_i,
  input  logic [NumIn-1:0]                       in_wen_i,
  input  logic [NumIn-1:0][DataWidth/8-1:0]      in_be_i,
  input  logic [NumIn-1:0][DataWidth-1:0]        in_data_i,
  output logic [NumIn-1:0]                       in_r_valid_o,
  output logic [NumIn-1:0][DataWidth-1:0]        in_r_data_o,
  output logic                                   out_req_o,
  input  logic                                   out_gnt_i,
  output logic [AddrWidth-1:0]                   out_add_o,
  output logic                                   out_wen_o,
  output logic [DataWidth/8-1:0]                 out_be_o,
  output logic [DataWidth-1:0]                   out_data_o,
  input  logic                                   out_r_valid_i,
  input  logic [DataWidth-1:0]                   out_r_data_i,
`ifdef HWPE_TCDM_ARB_STATS_EN
  input  logic                                   stats_clr_i,
  output logic [NumIn-1:0][31:0]                 grant_cnt_o,
  output logic [31:0]                            stall_cnt_o,
`endif
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
  output logic                                   busy_o
);

  localparam int unsigned IdxW = $clog2(NumIn);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding+1);

  logic [NumIn-1:0] eligible;
  logic [IdxW-1:0]  ptr_q, lock_idx_q, sel_idx, head_idx;
  logic             lock_q, sel_valid, fifo_full, fifo_empty;
  logic             grant, push, pop;
  int unsigned      cand;

  logic [IdxW-1:0]  fifo_q [MaxOutstanding];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding-1)) ? '0 : p + 1'b1;
  endfunction

  assign eligible   = in_req_i & en_i;
  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = fifo_q[rd_ptr_q];

  // Pick the locked input, else the first eligible input at or after ptr_q.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = lock_idx_q;
    cand      = 0;
    if (lock_q) begin
      sel_valid = 1'b1;
    end else begin
      for (int unsigned o = 0; o < NumIn; o++) begin
        cand = 32'(ptr_q) + o;
        if (cand >= NumIn) cand = cand - NumIn;
        if (!sel_valid && eligible[IdxW'(cand)]) begin
          sel_valid = 1'b1;
          sel_idx   = IdxW'(cand);
        end
      end
    end
  end

  // The full check uses registered occupancy, so a same-cycle pop never bypasses.
  assign out_req_o  = sel_valid && !fifo_full;
  assign grant      = out_req_o && out_gnt_i;
  assign push       = grant;
  assign pop        = out_r_valid_i && !fifo_empty;
  assign out_add_o  = in_add_i[sel_idx];
  assign out_wen_o  = in_wen_i[sel_idx];
  assign out_be_o   = in_be_i[sel_idx];
  assign out_data_o = in_data_i[sel_idx];

  // One-hot grant back to the selected requester.
  always_comb begin
    in_gnt_o = '0;
    if (grant) in_gnt_o[sel_idx] = 1'b1;
  end

  // Route responses to the FIFO head; a response with an empty FIFO is dropped.
  always_comb begin
    in_r_valid_o = '0;
    if (pop) in_r_valid_o[head_idx] = 1'b1;
  end

  assign in_r_data_o   = {NumIn{out_r_data_i}};
  assign outstanding_o = cnt_q;
  assign busy_o        = (|eligible) || lock_q || !fifo_empty;

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (grant) begin
        ptr_q  <= (sel_idx == IdxW'(NumIn-1)) ? '0 : sel_idx + 1'b1;
        lock_q <= 1'b0;
      end else if (out_req_o && !out_gnt_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end
    end
  end

  // Source-ID FIFO of granted-but-unanswered transactions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel_idx;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef HWPE_TCDM_ARB_STATS_EN
  // Saturating grant and stall counters; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else if (stats_clr_i) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int unsigned k = 0; k < NumIn; k++) begin
        if (in_gnt_o[k] && (grant_cnt_o[k] != 32'hFFFF_FFFF))
          grant_cnt_o[k] <= grant_cnt_o[k] + 32'd1;
      end
      if (out_req_o && !out_gnt_i && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

  // A response must always have a matching outstanding grant.
  a_rsp_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_r_valid_i |-> !fifo_empty);

  // Software must keep a locked input enabled until its grant.
  a_lock_enable_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> en_i[lock_idx_q]);

endmodule

// File: tb/tb_hwpe_tcdm_rr_arbiter.sv
// Self-checking bench for hwpe_tcdm_rr_arbiter: scoreboard of expected
// response routing plus directed arbitration scenarios.
module tb_hwpe_tcdm_rr_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       en_i, in_req_i, in_gnt_o, in_wen_i, in_r_valid_o;
  logic [1:0][31:0] in_add_i;
  logic [1:0][31:0] in_be_i;
  logic [1:0][255:0] in_data_i, in_r_data_o;
  logic             out_req_o, out_gnt_i, out_wen_o;
  logic [31:0]      out_add_o, out_be_o;
  logic [255:0]     out_data_o;
  logic             out_r_valid_i = 1'b0;
  logic [255:0]     out_r_data_i  = '0;
  logic [2:0]       outstanding_o;
  logic             busy_o;
`ifdef HWPE_TCDM_ARB_STATS_EN
  logic             stats_clr_i = 1'b0;
  logic [1:0][31:0] grant_cnt_o;
  logic [31:0]      stall_cnt_o;
`endif

  hwpe_tcdm_rr_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
    .in_wen_i(in_wen_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
    .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
    .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_data_o(out_data_o),
    .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
`ifdef HWPE_TCDM_ARB_STATS_EN
    .stats_clr_i(stats_clr_i), .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int           src;
    logic [255:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   gnt_log[$];
  int   checks = 0;
  int   failures = 0;
  int   rsp_seq = 0;
  int   rsp_req_cnt = 0;
  int   rsp_done_cnt = 0;
  bit   auto_rsp = 1'b0;
  int   base, errs;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int count_src(input int from, input int to, input int src);
    int n = 0;
    for (int i = from; i < to && i < gnt_log.size(); i++)
      if (gnt_log[i] == src) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: check responses against the scoreboard, record new grants.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else begin
      if (out_r_valid_i) begin
        if (exp_q.size() == 0) begin
          check_val("rsp_unexp_valid", in_r_valid_o, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("rsp_route", in_r_valid_o, 2'b01 << mon_e.src);
          check_val("rsp_data", in_r_data_o[mon_e.src], mon_e.data);
        end
      end
      check_val("gnt_onehot", $onehot0(in_gnt_o), 1);
      for (int k = 0; k < 2; k++) begin
        if (in_gnt_o[k]) begin
          exp_q.push_back('{k, 256'hCAFE + rsp_seq});
          rsp_seq++;
          gnt_log.push_back(k);
        end
      end
    end
  end

  // Downstream memory model: answers in order, automatically or on demand.
  always @(posedge clk_i) begin
    #1;
    if (rst_ni && exp_q.size() > 0 && (auto_rsp || rsp_req_cnt > rsp_done_cnt)) begin
      out_r_valid_i = 1'b1;
      out_r_data_i  = exp_q[0].data;
      if (rsp_req_cnt > rsp_done_cnt) rsp_done_cnt++;
    end else begin
      out_r_valid_i = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; en_i = '0; in_req_i = '0; in_add_i = '0; in_wen_i = '0;
    in_be_i = '0; in_data_i = '0; out_gnt_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_gnt", in_gnt_o, 0);
    check_val("rst_rvalid", in_r_valid_o, 0);
    check_val("rst_req", out_req_o, 0);
    check_val("rst_occ", outstanding_o, 0);
    check_val("rst_busy", busy_o, 0);
    rst_ni = 1'b1;

    // Single requester: input 1 reads 0x100.
    step();
    en_i = 2'b11; in_req_i = 2'b10; in_add_i[1] = 32'h100; in_wen_i = 2'b11;
    in_be_i[1] = '1; out_gnt_i = 1'b1; auto_rsp = 1'b1;
    @(negedge clk_i);
    check_val("t1_gnt", in_gnt_o, 2'b10);
    check_val("t1_add", out_add_o, 32'h100);
    check_val("t1_wen", out_wen_o, 1);
    check_val("t1_be", out_be_o, 32'hFFFF_FFFF);
    step();
    in_req_i = 2'b00;
    @(negedge clk_i);
    check_val("t1_occ", outstanding_o, 1);
    step();
    @(negedge clk_i);
    check_val("t1_drain", outstanding_o, 0);
    check_val("t1_busy", busy_o, 0);

    // Fairness over 100 grants.
    step();
    base = gnt_log.size();
    in_req_i = 2'b11; in_add_i[0] = 32'h200; in_add_i[1] = 32'h300;
    repeat (100) step();
    in_req_i = 2'b00;
    repeat (3) step();
    @(negedge clk_i);
    check_val("t2_cnt0", count_src(base, base + 100, 0), 50);
    check_val("t2_cnt1", count_src(base, base + 100, 1), 50);
    errs = 0;
    for (int i = 0; i < 100 && base + i < gnt_log.size(); i++)
      if (gnt_log[base + i] != (i % 2)) errs++;
    check_val("t2_alternate", errs, 0);
    check_val("t2_drain", outstanding_o, 0);

    // Lock: input 0 stalls with the pointer at input 1.
    step();
    in_req_i = 2'b01; in_add_i[0] = 32'hA00; in_add_i[1] = 32'hB00;
    @(negedge clk_i);
    check_val("t3_pre_gnt", in_gnt_o, 2'b01);
    step();
    out_gnt_i = 1'b0;
    @(negedge clk_i);
    check_val("t3_req", out_req_o, 1);
    check_val("t3_add_c1", out_add_o, 32'hA00);
    step();
    in_req_i = 2'b11;
    @(negedge clk_i);
    check_val("t3_add_c2", out_add_o, 32'hA00);
    check_val("t3_gnt_c2", in_gnt_o, 2'b00);
    step();
    @(negedge clk_i);
    check_val("t3_add_c3", out_add_o, 32'hA00);
    step();
    out_gnt_i = 1'b1;
    @(negedge clk_i);
    check_val("t3_gnt_c4", in_gnt_o, 2'b01);
    step();
    @(negedge clk_i);
    check_val("t3_gnt_next", in_gnt_o, 2'b10);
    step();
    in_req_i = 2'b00;
    repeat (3) step();

    // FIFO full with responses withheld.
    auto_rsp = 1'b0;
    base = gnt_log.size();
    in_req_i = 2'b11;
    repeat (5) step();
    @(negedge clk_i);
    check_val("t4_full_req", out_req_o, 0);
    check_val("t4_full_gnt", in_gnt_o, 0);
    check_val("t4_occ", outstanding_o, 4);
    check_val("t4_ngrants", gnt_log.size() - base, 4);
    rsp_req_cnt++;
    @(negedge clk_i);
    check_val("t4_nobypass", out_req_o, 0);
    @(negedge clk_i);
    check_val("t4_reopen", out_req_o, 1);
    check_val("t4_regnt", in_gnt_o, 2'b01);
    step();
    in_req_i = 2'b00; auto_rsp = 1'b1;
    repeat (8) step();
    @(negedge clk_i);
    check_val("t4_drain", outstanding_o, 0);

    // Enable mask, then alternation resumes from the pointer.
    step();
    base = gnt_log.size();
    en_i = 2'b01; in_req_i = 2'b11;
    repeat (4) step();
    en_i = 2'b11;
    repeat (2) step();
    in_req_i = 2'b00;
    repeat (3) step();
    @(negedge clk_i);
    check_val("t5_len", gnt_log.size() - base, 6);
    check_val("t5_masked_src1", count_src(base, base + 4, 1), 0);
    if (gnt_log.size() >= base + 6) begin
      check_val("t5_resume0", gnt_log[base + 4], 1);
      check_val("t5_resume1", gnt_log[base + 5], 0);
    end

    // Reset with 3 outstanding and input 1 locked.
    step();
    auto_rsp = 1'b0;
    in_req_i = 2'b11;
    repeat (3) step();
    in_req_i = 2'b10; out_gnt_i = 1'b0;
    @(negedge clk_i);
    check_val("t6_occ", outstanding_o, 3);
    check_val("t6_lock_add", out_add_o, 32'hB00);
    step();
    @(negedge clk_i);
    check_val("t6_busy", busy_o, 1);
    rst_ni = 1'b0; in_req_i = 2'b00;
    #1;
    check_val("t6_rst_gnt", in_gnt_o, 0);
    check_val("t6_rst_rvalid", in_r_valid_o, 0);
    check_val("t6_rst_req", out_req_o, 0);
    check_val("t6_rst_occ", outstanding_o, 0);
    check_val("t6_rst_busy", busy_o, 0);
    step();
    step();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    in_req_i = 2'b11; out_gnt_i = 1'b1; auto_rsp = 1'b1;
    @(negedge clk_i);
    check_val("t6_first_gnt", in_gnt_o, 2'b01);
    step();
    in_req_i = 2'b00;
    repeat (4) step();
    @(negedge clk_i);
    check_val("t6_drain", outstanding_o, 0);
    check_val("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
